// File: rtl/nonce_search_controller.sv
// Nonce search initiator: walks a nonce range through an external SHA-256 block until a hash meets the target.
// Optional WAIT watchdog built only when NONCE_SEARCH_WATCHDOG_EN is defined.
module nonce_search_controller #(
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         abort,
  input  logic [407:0] header_prefix,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] target,
  output logic [439:0] sha_msg,
  output logic         sha_begin,
  input  logic         sha_done,
  input  logic [255:0] sha_hash,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         error,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [31:0]  attempts
);

  // state     | meaning
  // IDLE      | no search running
  // LAUNCH    | sha_begin pulse for the current nonce
  // WAIT      | waiting for a sha_done rising edge
  // CHECK     | compare latched hash, pick next nonce
  // FOUND     | hash met target, results held
  // EXHAUSTED | range done without a hit
  // ERROR     | watchdog expired in WAIT
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CHECK, FOUND, EXHAUSTED, ERROR} stateT;

  stateT        state, nextState;
  logic [407:0] prefixQ;
  logic [255:0] targetQ;
  logic [255:0] hashQ;
  logic [31:0]  nonce;
  logic [31:0]  nonceEndQ;
  logic         shaDoneQ;
  logic         doneRise;
  logic         hashOk;
  logic         wdExpired;

  assign doneRise = sha_done & ~shaDoneQ;
  assign hashOk   = (hashQ <= targetQ);
  assign sha_msg  = {prefixQ, nonce};

`ifdef NONCE_SEARCH_WATCHDOG_EN
  localparam int WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wdCnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wdCnt <= '0;
    end else if (state == LAUNCH) begin
      wdCnt <= WdW'(TIMEOUT_CYCLES - 1);
    end else if (state == WAIT && wdCnt != '0) begin
      wdCnt <= wdCnt - 1'b1;
    end
  end

  assign wdExpired = (wdCnt == '0);
  assign error     = (state == ERROR);
`else
  // Without the watchdog a timeout can never be reached; the parameter is kept for a uniform interface.
  assign wdExpired = (TIMEOUT_CYCLES < 0);
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    sha_begin = 1'b0;
    busy      = 1'b0;
    found     = 1'b0;
    exhausted = 1'b0;
    case (state)
      IDLE, ERROR: begin
        if (start) nextState = LAUNCH;
      end
      FOUND: begin
        found = 1'b1;
        if (start) nextState = LAUNCH;
      end
      EXHAUSTED: begin
        exhausted = 1'b1;
        if (start) nextState = LAUNCH;
      end
      LAUNCH: begin
        busy      = 1'b1;
        sha_begin = 1'b1;
        nextState = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (doneRise)       nextState = CHECK;
        else if (wdExpired) nextState = ERROR;
      end
      CHECK: begin
        busy = 1'b1;
        if (hashOk)                  nextState = FOUND;
        else if (nonce == nonceEndQ) nextState = EXHAUSTED;
        else                         nextState = LAUNCH;
      end
      default: nextState = IDLE;
    endcase
    if (abort) nextState = IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prefixQ     <= '0;
      targetQ     <= '0;
      hashQ       <= '0;
      nonce       <= '0;
      nonceEndQ   <= '0;
      shaDoneQ    <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
      attempts    <= '0;
    end else begin
      shaDoneQ <= sha_done;
      if (!abort) begin
        case (state)
          IDLE, FOUND, EXHAUSTED, ERROR: begin
            if (start) begin
              prefixQ   <= header_prefix;
              targetQ   <= target;
              nonce     <= nonce_start;
              nonceEndQ <= nonce_end;
              attempts  <= '0;
            end
          end
          WAIT: begin
            if (doneRise) hashQ <= sha_hash;
          end
          CHECK: begin
            if (attempts != '1) attempts <= attempts + 1'b1;
            if (hashOk) begin
              found_nonce <= nonce;
              found_hash  <= hashQ;
            end else if (nonce != nonceEndQ) begin
              nonce <= nonce + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nonce_search_controller.sv
// Self-checking bench for nonce_search_controller with a behavioural SHA latency model and a nonce scoreboard.
module tb_nonce_search_controller;

  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [407:0] header_prefix = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic [255:0] target = '0;
  logic [439:0] sha_msg;
  logic         sha_begin;
  logic         sha_done;
  logic [255:0] sha_hash = '0;
  logic         busy, found, exhausted, error;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic [31:0]  attempts;

  int passCnt = 0;
  int totalCnt = 0;
  int cycleCnt = 0;

  int           latency = 2;
  bit           holdLow = 1'b0;
  bit           specialEn = 1'b0;
  logic [31:0]  specialNonce = '0;
  logic [255:0] specialHash = '0;
  logic         modelDone = 1'b0;
  logic         forceDone = 1'b0;
  int           lat = 0;
  logic [31:0]  pending = '0;

  logic [31:0]  obsNonce[$];
  logic [407:0] obsPrefix[$];
  int           obsCycle[$];
  logic [31:0]  expNonce[$];
  logic [407:0] expPrefix;

  assign sha_done = modelDone | forceDone;

  nonce_search_controller #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .header_prefix(header_prefix), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .target(target), .sha_msg(sha_msg), .sha_begin(sha_begin), .sha_done(sha_done),
    .sha_hash(sha_hash), .busy(busy), .found(found), .exhausted(exhausted), .error(error),
    .found_nonce(found_nonce), .found_hash(found_hash), .attempts(attempts)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  function automatic logic [255:0] modelHash(input logic [31:0] n);
    if (specialEn && n == specialNonce) return specialHash;
    return {8'hFF, 120'h0, 96'hC0FFEE, n};
  endfunction

  // SHA model: done rises L cycles after the begin cycle, drops on the next begin.
  always @(negedge clk) begin
    if (sha_begin) begin
      obsNonce.push_back(sha_msg[31:0]);
      obsPrefix.push_back(sha_msg[439:32]);
      obsCycle.push_back(cycleCnt);
      pending   = sha_msg[31:0];
      lat       = latency;
      modelDone = 1'b0;
    end else if (lat > 0) begin
      lat--;
      if (lat == 0 && !holdLow) begin
        modelDone = 1'b1;
        sha_hash  = modelHash(pending);
      end
    end
  end

  task automatic startSearch(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t);
    @(posedge clk); #1;
    header_prefix = {s[23:0], {12{s ^ 32'h5A5A_1234}}};
    expPrefix     = header_prefix;
    nonce_start   = s;
    nonce_end     = e;
    target        = t;
    start         = 1'b1;
    @(posedge clk); #1;
    start         = 1'b0;
    header_prefix = ~header_prefix;
  endtask

  task automatic waitEnd(input int budget, output bit timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (found | exhausted | error) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    totalCnt++;
    if (sha_msg !== '0) $display("FAIL reset_sha_msg: got %h expected 0", sha_msg); else passCnt++;
    totalCnt++;
    if (found_nonce !== '0) $display("FAIL reset_found_nonce: got %h expected 0", found_nonce); else passCnt++;
    totalCnt++;
    if (found_hash !== '0) $display("FAIL reset_found_hash: got %h expected 0", found_hash); else passCnt++;
    totalCnt++;
    if (attempts !== '0) $display("FAIL reset_attempts: got %0d expected 0", attempts); else passCnt++;
    totalCnt++;
    if ({busy, found, exhausted, error, sha_begin} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {busy, found, exhausted, error, sha_begin});
    else passCnt++;
    n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int base;
    bit to;
    logic [31:0] e;
    latency = 3;
    base = obsNonce.size();
    expNonce.push_back(32'd5);
    startSearch(32'd5, 32'd5, '1);
    waitEnd(100, to);
    totalCnt++;
    if (to) $display("FAIL single_timeout: got no terminal state expected found"); else passCnt++;
    totalCnt++;
    if (obsNonce.size() - base !== 1) $display("FAIL single_begins: got %0d expected 1", obsNonce.size() - base); else passCnt++;
    while (expNonce.size() > 0) begin
      e = expNonce.pop_front();
      totalCnt++;
      if (base >= obsNonce.size()) $display("FAIL single_nonce: got none expected %h", e);
      else if (obsNonce[base] !== e) $display("FAIL single_nonce: got %h expected %h", obsNonce[base], e);
      else passCnt++;
      totalCnt++;
      if (base >= obsPrefix.size() || obsPrefix[base] !== expPrefix) $display("FAIL single_prefix: got other expected %h", expPrefix);
      else passCnt++;
      base++;
    end
    totalCnt++;
    if ({found, exhausted, busy} !== 3'b100) $display("FAIL single_flags: got %b expected 100", {found, exhausted, busy}); else passCnt++;
    totalCnt++;
    if (found_nonce !== 32'd5) $display("FAIL single_found_nonce: got %h expected 5", found_nonce); else passCnt++;
    totalCnt++;
    if (found_hash !== modelHash(32'd5)) $display("FAIL single_found_hash: got %h expected %h", found_hash, modelHash(32'd5)); else passCnt++;
    totalCnt++;
    if (attempts !== 32'd1) $display("FAIL single_attempts: got %0d expected 1", attempts); else passCnt++;
  endtask

  task automatic test_back_to_back;
    int base;
    bit to;
    logic [31:0] e;
    latency = 2;
    base = obsNonce.size();
    expNonce.push_back(32'd40);
    expNonce.push_back(32'd41);
    startSearch(32'd40, 32'd41, '0);
    totalCnt++;
    if ({found, busy} !== 2'b01) $display("FAIL b2b_restart_from_found: got %b expected 01", {found, busy}); else passCnt++;
    @(posedge clk); #1;
    nonce_start = 32'd100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitEnd(100, to);
    totalCnt++;
    if (to) $display("FAIL b2b_timeout: got no terminal state expected exhausted"); else passCnt++;
    totalCnt++;
    if (obsNonce.size() - base !== 2) $display("FAIL b2b_begins: got %0d expected 2", obsNonce.size() - base); else passCnt++;
    while (expNonce.size() > 0) begin
      e = expNonce.pop_front();
      totalCnt++;
      if (base >= obsNonce.size()) $display("FAIL b2b_nonce: got none expected %h", e);
      else if (obsNonce[base] !== e) $display("FAIL b2b_nonce: got %h expected %h", obsNonce[base], e);
      else passCnt++;
      base++;
    end
    totalCnt++;
    if ({exhausted, attempts} !== {1'b1, 32'd2}) $display("FAIL b2b_result: got ex=%b att=%0d expected ex=1 att=2", exhausted, attempts); else passCnt++;
  endtask

  task automatic test_range(input string name, input logic [31:0] s, input logic [31:0] e, input int lt, input int n);
    int base;
    int first;
    bit to;
    logic [31:0] x;
    latency = lt;
    base = obsNonce.size();
    first = base;
    for (int i = 0; i < n; i++) expNonce.push_back(s + 32'(i));
    startSearch(s, e, '0);
    waitEnd(40 * n + 40, to);
    totalCnt++;
    if (to) $display("FAIL %s_timeout: got no terminal state expected exhausted", name); else passCnt++;
    totalCnt++;
    if (obsNonce.size() - base !== n) $display("FAIL %s_begins: got %0d expected %0d", name, obsNonce.size() - base, n); else passCnt++;
    while (expNonce.size() > 0) begin
      x = expNonce.pop_front();
      totalCnt++;
      if (base >= obsNonce.size()) $display("FAIL %s_nonce: got none expected %h", name, x);
      else if (obsNonce[base] !== x) $display("FAIL %s_nonce: got %h expected %h", name, obsNonce[base], x);
      else passCnt++;
      if (base > first && base < obsCycle.size()) begin
        totalCnt++;
        if (obsCycle[base] - obsCycle[base-1] !== lt + 2)
          $display("FAIL %s_spacing: got %0d expected %0d", name, obsCycle[base] - obsCycle[base-1], lt + 2);
        else passCnt++;
      end
      base++;
    end
    totalCnt++;
    if ({exhausted, found, busy} !== 3'b100) $display("FAIL %s_flags: got %b expected 100", name, {exhausted, found, busy}); else passCnt++;
    totalCnt++;
    if (attempts !== 32'(n)) $display("FAIL %s_attempts: got %0d expected %0d", name, attempts, n); else passCnt++;
  endtask

  task automatic test_exact;
    int base;
    bit to;
    logic [31:0] e;
    logic [255:0] tgt;
    tgt = {8'h00, 120'h0123_4567_89AB_CDEF_0011_2233_4455_66, 128'h7788_99AA_BBCC_DDEE_FF00_1122_3344_5566};
    latency = 2;
    specialEn = 1'b1;
    specialNonce = 32'd7;
    specialHash = tgt;
    base = obsNonce.size();
    expNonce.push_back(32'd5);
    expNonce.push_back(32'd6);
    expNonce.push_back(32'd7);
    startSearch(32'd5, 32'd9, tgt);
    waitEnd(100, to);
    totalCnt++;
    if (to) $display("FAIL exact_timeout: got no terminal state expected found"); else passCnt++;
    totalCnt++;
    if (obsNonce.size() - base !== 3) $display("FAIL exact_begins: got %0d expected 3", obsNonce.size() - base); else passCnt++;
    while (expNonce.size() > 0) begin
      e = expNonce.pop_front();
      totalCnt++;
      if (base >= obsNonce.size()) $display("FAIL exact_nonce: got none expected %h", e);
      else if (obsNonce[base] !== e) $display("FAIL exact_nonce: got %h expected %h", obsNonce[base], e);
      else passCnt++;
      base++;
    end
    totalCnt++;
    if ({found, found_nonce} !== {1'b1, 32'd7}) $display("FAIL exact_found: got f=%b n=%h expected f=1 n=7", found, found_nonce); else passCnt++;
    totalCnt++;
    if (found_hash !== tgt) $display("FAIL exact_hash: got %h expected %h", found_hash, tgt); else passCnt++;
    totalCnt++;
    if (attempts !== 32'd3) $display("FAIL exact_attempts: got %0d expected 3", attempts); else passCnt++;
    specialEn = 1'b0;
  endtask

  task automatic test_abort;
    int base;
    latency = 3;
    holdLow = 1'b1;
    startSearch(32'd20, 32'd30, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    totalCnt++;
    if ({busy, found, exhausted, error} !== 4'b0) $display("FAIL abort_idle: got %b expected 0000", {busy, found, exhausted, error}); else passCnt++;
    totalCnt++;
    if (found_nonce !== 32'd7) $display("FAIL abort_results_kept: got %h expected 7", found_nonce); else passCnt++;
    forceDone = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    totalCnt++;
    if ({busy, found, exhausted} !== 3'b0 || attempts !== '0)
      $display("FAIL abort_late_done: got flags=%b att=%0d expected flags=000 att=0", {busy, found, exhausted}, attempts);
    else passCnt++;
    forceDone = 1'b0;
    holdLow = 1'b0;
    base = obsNonce.size();
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (busy !== 1'b0 || obsNonce.size() !== base)
      $display("FAIL abort_beats_start: got busy=%b begins=%0d expected busy=0 begins=0", busy, obsNonce.size() - base);
    else passCnt++;
  endtask

  task automatic test_watchdog;
    int base;
    holdLow = 1'b1;
    latency = 1;
    base = obsNonce.size();
    startSearch(32'd50, 32'd60, '0);
`ifdef NONCE_SEARCH_WATCHDOG_EN
    begin
      bit to;
      int errCycle;
      to = 1'b1;
      errCycle = 0;
      for (int i = 0; i < TIMEOUT + 100; i++) begin
        @(negedge clk);
        if (error) begin
          to = 1'b0;
          errCycle = cycleCnt;
          break;
        end
      end
      totalCnt++;
      if (to || base >= obsCycle.size()) $display("FAIL watchdog_error: got no error expected error");
      else if (errCycle - (obsCycle[base] + 1) !== TIMEOUT)
        $display("FAIL watchdog_delay: got %0d expected %0d", errCycle - (obsCycle[base] + 1), TIMEOUT);
      else passCnt++;
      totalCnt++;
      if ({busy, attempts} !== {1'b0, 32'd0}) $display("FAIL watchdog_state: got busy=%b att=%0d expected busy=0 att=0", busy, attempts); else passCnt++;
    end
`else
    repeat (TIMEOUT + 50) @(negedge clk);
    totalCnt++;
    if ({busy, error} !== 2'b10) $display("FAIL watchdog_off_wait: got busy=%b err=%b expected busy=1 err=0", busy, error); else passCnt++;
    totalCnt++;
    if (obsNonce.size() - base !== 1) $display("FAIL watchdog_off_begins: got %0d expected 1", obsNonce.size() - base); else passCnt++;
`endif
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    holdLow = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_range("exhaust", 32'd10, 32'd12, 4, 3);
    test_range("wrap", 32'hFFFF_FFFE, 32'h0000_0001, 1, 4);
    test_exact();
    test_abort();
    test_watchdog();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
